// File: rtl/list_sum_arbiter_if.sv
// Bundle between list_sum_arbiter and its clients / list-sum controller.
// The slave modport is the arbiter's view. The master modport is the view of
// the client and controller side.
//
// Handshake semantics:
//   Client side.
//     req[i] is a level request. The client holds it high until it sees
//     ack[i]. ack[i] is a one-cycle pulse, and result/err are valid in that
//     same cycle. grant shows the current owner, and is 0 while idle.
//   Controller side.
//     ctrl_start is a one-cycle pulse, and head_out is valid from that cycle
//     until the next grant. ctrl_done is a level that the controller holds
//     in its DONE state. ctrl_sum is sampled in the cycle ctrl_done is seen.
//     ctrl_abort is a one-cycle pulse that sends the controller back to START.
interface list_sum_arbiter_if #(
    parameter int NREQ = 4,
    parameter int AW   = 16,
    parameter int N    = 32
);
    logic [NREQ-1:0]    req;
    logic [NREQ*AW-1:0] head_ptr;
    logic [NREQ-1:0]    grant;
    logic [NREQ-1:0]    ack;
    logic [N-1:0]       result;
    logic               err;
    logic               busy;
    logic [AW-1:0]      head_out;
    logic               ctrl_start;
    logic               ctrl_done;
    logic [N-1:0]       ctrl_sum;
    logic               ctrl_abort;
    logic [1:0]         state_dbg;

    modport slave (
        input  req, head_ptr, ctrl_done, ctrl_sum,
        output grant, ack, result, err, busy, head_out,
               ctrl_start, ctrl_abort, state_dbg
    );

    modport master (
        output req, head_ptr, ctrl_done, ctrl_sum,
        input  grant, ack, result, err, busy, head_out,
               ctrl_start, ctrl_abort, state_dbg
    );
endinterface

// File: rtl/list_sum_arbiter.sv
// Round-robin scheduler that shares one linked-list sum datapath among NREQ
// requesters. Each job follows the sequence grant, start pulse, wait for done,
// then a one-cycle ack carrying the sum. All outputs are registered.
// Optional feature macro LSA_TIMEOUT_EN adds a WAIT watchdog. When it fires,
// the block acks the job with err=1 and result=0, and pulses ctrl_abort.
module list_sum_arbiter #(
    parameter int NREQ        = 4,
    parameter int AW          = 16,
    parameter int N           = 32,
    parameter int TIMEOUT_CYC = 1024
) (
    input logic               clk,
    input logic               rst,
    list_sum_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    localparam int RRW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t          state, state_nxt;
    logic [RRW-1:0]  rr_q, rr_nxt;
    logic [NREQ-1:0] grant_q, grant_nxt;
    logic [NREQ-1:0] ack_q, ack_nxt;
    logic [N-1:0]    result_q, result_nxt;
    logic [AW-1:0]   head_q, head_nxt;
    logic            start_q, start_nxt;
    logic            found;
    logic [RRW-1:0]  win;

`ifdef LSA_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC) + 1;
    logic [CW-1:0] cnt_q, cnt_nxt;
    logic          err_q, err_nxt;
    logic          abort_q, abort_nxt;
`endif

    // Find the first requester after the last winner. The search wraps
    // modulo NREQ, so the last winner gets the lowest priority.
    always_comb begin
        found = 1'b0;
        win   = rr_q;
        for (int k = 1; k <= NREQ; k++) begin
            if (!found && bus.req[(int'(rr_q) + k) % NREQ]) begin
                found = 1'b1;
                win   = RRW'((int'(rr_q) + k) % NREQ);
            end
        end
    end

    // Next state, and next values of every registered output.
    always_comb begin
        state_nxt  = state;
        rr_nxt     = rr_q;
        grant_nxt  = grant_q;
        ack_nxt    = '0;
        result_nxt = result_q;
        head_nxt   = head_q;
        start_nxt  = 1'b0;
`ifdef LSA_TIMEOUT_EN
        cnt_nxt    = cnt_q;
        err_nxt    = 1'b0;
        abort_nxt  = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                // A done level still held from the previous job blocks a new launch.
                if (found && !bus.ctrl_done) begin
                    grant_nxt = NREQ'(1) << win;
                    head_nxt  = bus.head_ptr[int'(win)*AW +: AW];
                    start_nxt = 1'b1;
                    rr_nxt    = win;
                    state_nxt = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
`ifdef LSA_TIMEOUT_EN
                cnt_nxt   = '0;
`endif
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                // If done and the watchdog fire in the same cycle, done wins.
                if (bus.ctrl_done) begin
                    result_nxt = bus.ctrl_sum;
                    ack_nxt    = grant_q;
                    state_nxt  = S_RESP;
                end
`ifdef LSA_TIMEOUT_EN
                else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
                    result_nxt = '0;
                    ack_nxt    = grant_q;
                    err_nxt    = 1'b1;
                    abort_nxt  = 1'b1;
                    state_nxt  = S_RESP;
                end else begin
                    cnt_nxt = cnt_q + CW'(1);
                end
`endif
            end
            S_RESP: begin
                grant_nxt = '0;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State and output registers. The reset puts the rr pointer at the
    // last requester, so requester 0 has top priority first.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            rr_q     <= RRW'(NREQ - 1);
            grant_q  <= '0;
            ack_q    <= '0;
            result_q <= '0;
            head_q   <= '0;
            start_q  <= 1'b0;
        end else begin
            state    <= state_nxt;
            rr_q     <= rr_nxt;
            grant_q  <= grant_nxt;
            ack_q    <= ack_nxt;
            result_q <= result_nxt;
            head_q   <= head_nxt;
            start_q  <= start_nxt;
        end
    end

`ifdef LSA_TIMEOUT_EN
    // Watchdog counter, and the err/abort pulses that go with a timed-out ack.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q   <= '0;
            err_q   <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_nxt;
            err_q   <= err_nxt;
            abort_q <= abort_nxt;
        end
    end

    assign bus.err        = err_q;
    assign bus.ctrl_abort = abort_q;
`else
    assign bus.err        = 1'b0;
    assign bus.ctrl_abort = 1'b0;
`endif

    assign bus.grant      = grant_q;
    assign bus.ack        = ack_q;
    assign bus.result     = result_q;
    assign bus.head_out   = head_q;
    assign bus.ctrl_start = start_q;
    assign bus.busy       = (state != S_IDLE);
    assign bus.state_dbg  = state;
endmodule

// File: tb/tb_list_sum_arbiter.sv
// Testbench for list_sum_arbiter.
// A job-level reference model runs on every falling edge. It predicts each
// grant from the rotation rule, and each ack from the done level the DUT
// sampled. Directed tests pin the model with hand-computed literals.
`timescale 1ns/1ps
module tb_list_sum_arbiter;
    localparam int NREQ = 4;
    localparam int AW   = 16;
    localparam int N    = 32;
    localparam int TO   = 16;

    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    list_sum_arbiter_if #(.NREQ(NREQ), .AW(AW), .N(N)) bus ();

    list_sum_arbiter #(.NREQ(NREQ), .AW(AW), .N(N), .TIMEOUT_CYC(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- list memory ----------------
    logic [N-1:0] mem_val [int];
    int           mem_next [int];

    task automatic add_node(input int addr, input logic [N-1:0] val, input int nxt);
        mem_val[addr]  = val;
        mem_next[addr] = nxt;
    endtask

    function automatic logic [N-1:0] list_sum(input logic [AW-1:0] head);
        logic [N-1:0] s = '0;
        int p = int'(head);
        for (int i = 0; i < 64; i++) begin
            if (p == 0 || !mem_val.exists(p)) break;
            s = s + mem_val[p];
            p = mem_next[p];
        end
        return s;
    endfunction

    // ---------------- controller model ----------------
    int c_k     = 2;
    int c_h     = 1;
    bit c_never = 1'b0;
    bit c_active = 1'b0;
    int c_cnt   = 0;
    int c_hold  = 0;
    logic [N-1:0] c_sum = '0;

    initial begin
        bus.ctrl_done = 1'b0;
        bus.ctrl_sum  = '0;
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                bus.ctrl_done = 1'b0;
                c_active = 1'b0;
                c_hold   = 0;
            end else begin
                #1;
                if (!bus.ctrl_done) bus.ctrl_sum = $urandom;
                if (bus.ctrl_start) begin
                    bus.ctrl_done = 1'b0;
                    c_hold   = 0;
                    c_active = !c_never;
                    c_cnt    = c_k;
                    c_sum    = list_sum(bus.head_out);
                end else if (bus.ctrl_abort) begin
                    c_active = 1'b0;
                    bus.ctrl_done = 1'b0;
                end else if (c_active) begin
                    c_cnt--;
                    if (c_cnt <= 0) begin
                        bus.ctrl_done = 1'b1;
                        bus.ctrl_sum  = c_sum;
                        c_hold   = c_h;
                        c_active = 1'b0;
                    end
                end else if (bus.ctrl_done) begin
                    c_hold--;
                    if (c_hold <= 0) bus.ctrl_done = 1'b0;
                end
            end
        end
    end

    // ---------------- reference model + compare ----------------
    logic [N-1:0]       exp_q [$];
    int                 g_log [$];
    int                 m_phase = 0;   // 0 idle, 1 job in flight, 2 response cycle
    int                 m_rr    = NREQ - 1;
    int                 m_owner = 0;
    int                 m_n     = 0;
    logic [N-1:0]       m_last  = '0;
    logic [AW-1:0]      m_head  = '0;
    int                 n_starts = 0;
    logic [NREQ-1:0]    prev_req = '0;
    logic               prev_done = 1'b0;
    logic [NREQ*AW-1:0] prev_head = '0;
    logic [NREQ-1:0]    e_grant, e_ack;
    logic               e_start, e_err, e_abort;

    function automatic int rr_pick(input logic [NREQ-1:0] r, input int last);
        for (int k = 1; k <= NREQ; k++)
            if (r[(last + k) % NREQ]) return (last + k) % NREQ;
        return -1;
    endfunction

    always @(negedge clk) begin
        if (bus.ctrl_start === 1'b1) n_starts++;
        if (!rst) begin
            m_phase = 0;
            m_rr    = NREQ - 1;
            m_last  = '0;
            m_head  = '0;
            exp_q.delete();
        end else begin
            e_grant = '0; e_ack = '0; e_start = 1'b0; e_err = 1'b0; e_abort = 1'b0;
            case (m_phase)
                0: begin
                    if (prev_req != '0 && !prev_done) begin
                        m_owner = rr_pick(prev_req, m_rr);
                        m_rr    = m_owner;
                        m_head  = prev_head[m_owner*AW +: AW];
                        exp_q.push_back(list_sum(m_head));
                        g_log.push_back(m_owner);
                        e_grant = NREQ'(1) << m_owner;
                        e_start = 1'b1;
                        m_n     = 0;
                        m_phase = 1;
                    end
                end
                1: begin
                    m_n++;
                    e_grant = NREQ'(1) << m_owner;
                    if (m_n >= 2 && prev_done) begin
                        e_ack = e_grant;
                        if (exp_q.size() > 0) m_last = exp_q.pop_front();
                        m_phase = 2;
                    end
`ifdef LSA_TIMEOUT_EN
                    else if (m_n == TO + 1) begin
                        e_ack   = e_grant;
                        e_err   = 1'b1;
                        e_abort = 1'b1;
                        m_last  = '0;
                        if (exp_q.size() > 0) void'(exp_q.pop_front());
                        m_phase = 2;
                    end
`endif
                end
                default: m_phase = 0;
            endcase
            chk("cmp_grant", bus.grant, e_grant);
            chk("cmp_ack", bus.ack, e_ack);
            chk("cmp_result", bus.result, m_last);
            chk("cmp_err", bus.err, e_err);
            chk("cmp_abort", bus.ctrl_abort, e_abort);
            chk("cmp_start", bus.ctrl_start, e_start);
            chk("cmp_head_out", bus.head_out, m_head);
            chk("cmp_busy", bus.busy, (e_grant != '0));
        end
        prev_req  = bus.req;
        prev_done = bus.ctrl_done;
        prev_head = bus.head_ptr;
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(input string name);
        int cyc = 0;
        while (bus.grant == '0 && cyc < 200) begin step(1); cyc++; end
        chk({name, "_grant_seen"}, (bus.grant != '0), 1);
    endtask

    task automatic wait_ack(input string name);
        int cyc = 0;
        do begin step(1); cyc++; end while (bus.ack == '0 && cyc < 200);
        chk({name, "_ack_seen"}, (bus.ack != '0), 1);
    endtask

    task automatic check_all_zero(input string name);
        chk({name, "_grant"}, bus.grant, 0);
        chk({name, "_ack"}, bus.ack, 0);
        chk({name, "_result"}, bus.result, 0);
        chk({name, "_err"}, bus.err, 0);
        chk({name, "_busy"}, bus.busy, 0);
        chk({name, "_head_out"}, bus.head_out, 0);
        chk({name, "_start"}, bus.ctrl_start, 0);
        chk({name, "_abort"}, bus.ctrl_abort, 0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int gap;
        int s0;
        int cyc;
        int order [8];
        order = '{0, 1, 2, 3, 0, 1, 2, 3};

        add_node(16'h0040, 32'd5, 16'h0044);
        add_node(16'h0044, 32'd7, 16'h0048);
        add_node(16'h0048, 32'd9, 0);
        add_node(16'h0100, 32'd1, 16'h0104);
        add_node(16'h0104, 32'd2, 16'h0108);
        add_node(16'h0108, 32'd3, 0);
        add_node(16'h0200, 32'd100, 0);
        add_node(16'h0300, 32'd11, 16'h0304);
        add_node(16'h0304, 32'd22, 0);

        rst = 1'b0;
        bus.req = '0;
        bus.head_ptr = {16'h0300, 16'h0200, 16'h0040, 16'h0100};
        step(3);
        check_all_zero("reset");
        rst = 1'b1;
        step(2);

        // Single request from requester 1, list {5,7,9}.
        c_k = 3;
        s0 = n_starts;
        bus.req = 4'b0010;
        wait_ack("t2");
        chk("t2_ack", bus.ack, 4'b0010);
        chk("t2_result", bus.result, 32'd21);
        chk("t2_err", bus.err, 0);
        chk("t2_head_out", bus.head_out, 16'h0040);
        bus.req = '0;
        step(1);
        chk("t2_ack_one_cycle", bus.ack, 0);
        step(3);
        chk("t2_start_pulses", n_starts - s0, 1);

        // Reset in the middle of WAIT, then the first grant after reset.
        c_k = 10;
        bus.req = 4'b0100;
        wait_grant("t1");
        chk("t1_grant", bus.grant, 4'b0100);
        step(5);
        chk("t1_busy_in_wait", bus.busy, 1);
        #2 rst = 1'b0;
        #1;
        check_all_zero("t1_mid_reset");
        bus.req = '0;
        step(2);
        rst = 1'b1;
        bus.req = 4'b1000;
        c_k = 2;
        wait_grant("t1b");
        chk("t1_grant_after_reset", bus.grant, 4'b1000);
        wait_ack("t1b");
        chk("t1_result", bus.result, 32'd33);
        bus.req = '0;
        step(3);

        // All four requesting: strict rotation 0,1,2,3,0,1,2,3.
        g_log.delete();
        bus.req = 4'b1111;
        repeat (8) wait_ack("t3");
        bus.req = '0;
        step(4);
        chk("t3_job_count", g_log.size(), 8);
        for (int i = 0; i < 8; i++)
            if (i < g_log.size()) chk("t3_order", g_log[i], order[i]);

        // The done level is held 3 cycles past RESP, so the regrant must wait.
        c_h = 4;
        bus.req = 4'b0001;
        wait_ack("t4");
        gap = 0;
        do begin step(1); gap++; end while ((bus.grant == '0 || gap == 1) && gap < 50);
        chk("t4_regrant_gap", gap, 4);
        chk("t4_regrant", bus.grant, 4'b0001);
        wait_ack("t4b");
        bus.req = '0;
        c_h = 1;
        step(6);

        // The owner drops req mid-WAIT. The job still completes, then the other requester is served.
        c_k = 6;
        bus.req = 4'b0011;
        wait_grant("t5");
        chk("t5_grant", bus.grant, 4'b0010);
        step(3);
        bus.req = 4'b0001;
        wait_ack("t5");
        chk("t5_ack", bus.ack, 4'b0010);
        chk("t5_result", bus.result, 32'd21);
        cyc = 0;
        do begin step(1); cyc++; end while (bus.grant != 4'b0001 && cyc < 50);
        chk("t5_next_grant", bus.grant, 4'b0001);
        wait_ack("t5b");
        chk("t5b_result", bus.result, 32'd6);
        bus.req = '0;
        step(3);

        // The controller never finishes.
        c_never = 1'b1;
        bus.req = 4'b0100;
        wait_grant("t6");
`ifdef LSA_TIMEOUT_EN
        wait_ack("t6");
        chk("t6_ack", bus.ack, 4'b0100);
        chk("t6_err", bus.err, 1);
        chk("t6_result", bus.result, 0);
        chk("t6_abort", bus.ctrl_abort, 1);
        bus.req = '0;
        c_never = 1'b0;
        step(4);
`else
        repeat (40) begin
            step(1);
            chk("t6_busy_held", bus.busy, 1);
            chk("t6_no_ack", bus.ack, 0);
        end
        #2 rst = 1'b0;
        #1;
        check_all_zero("t6_recover_reset");
        bus.req = '0;
        c_never = 1'b0;
        step(2);
        rst = 1'b1;
        step(3);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        n_errors++;
        $display("FAIL watchdog: got simulation still running, expected end of sequence");
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
